reg_adc_chanbank: RTL and testbench

Parametrised per-channel ADC settings register bank, the multi-channel successor of the single-channel OpenADC settings registers. It sits on the same USB register bus (`reg_address`/`reg_bytecnt`/`reg_datai`/`reg_datao`/`reg_read`/`reg_write`) and drives per-channel gain, trigger level and enable to the capture path. Writes go through an indirect channel selector into shadow registers. A commit state machine transfers all shadow values to the live outputs atomically, deferring the transfer while a capture is in progress.

---
 rtl/reg_adc_chanbank_pkg.sv | 37 +++
 rtl/reg_adc_chanbank_commit_fsm.sv | 62 ++++++
 rtl/reg_adc_chanbank.sv | 167 ++++++++++++++++
 tb/tb_reg_adc_chanbank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_adc_chanbank_pkg.sv
// Shared definitions for the per-channel ADC settings bank: register addresses,
// commit-state encodings and byte-lane helpers for registers up to 16 bits wide.
package reg_adc_chanbank_pkg;

    localparam logic [7:0] CHAN_SELECT_ADDR = 8'h40;
    localparam logic [7:0] CHAN_GAIN_ADDR   = 8'h41;
    localparam logic [7:0] CHAN_LEVEL_ADDR  = 8'h42;
    localparam logic [7:0] CHAN_ENABLE_ADDR = 8'h43;
    localparam logic [7:0] CHAN_COMMIT_ADDR = 8'h44;
    localparam logic [7:0] CHAN_INFO_ADDR   = 8'h45;

    typedef enum logic [1:0] {
        COMMIT_IDLE    = 2'd0,
        COMMIT_PENDING = 2'd1,
        COMMIT_APPLY   = 2'd2
    } commit_state_t;

    // Callers truncate the result to the real register width, so bits past it drop out.
    function automatic logic [15:0] merge_byte16(input logic [15:0] cur, input logic [7:0] data,
                                                 input logic sel0, input logic sel1);
        logic [15:0] res;
        res = cur;
        if (sel0) res[7:0] = data;
        if (sel1) res[15:8] = data;
        return res;
    endfunction

    function automatic logic [7:0] read_byte16(input logic [15:0] val, input logic sel0,
                                               input logic sel1);
        logic [7:0] res;
        res = 8'h00;
        if (sel0) res = val[7:0];
        if (sel1) res = val[15:8];
        return res;
    endfunction

endpackage

// File: rtl/reg_adc_chanbank_commit_fsm.sv
// Commit sequencer for the shadow->live transfer; only present when
// REG_CHANBANK_SHADOW_EN is defined.
`ifdef REG_CHANBANK_SHADOW_EN
module reg_commit_fsm
    import reg_adc_chanbank_pkg::*;
(
    input  logic clk_usb,
    input  logic reset_n,
    input  logic commit_req,
    input  logic abort_req,
    input  logic capture_busy,
    input  logic overrun_clear,
    output logic apply,
    output logic pending,
    output logic done,
    output logic overrun
);
    commit_state_t state;

    assign apply = (state == COMMIT_APPLY);

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state   <= COMMIT_IDLE;
            pending <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= (state == COMMIT_APPLY);
            if (overrun_clear)
                overrun <= 1'b0;
            else if (state == COMMIT_PENDING && commit_req && !abort_req)
                overrun <= 1'b1;

            // Abort always wins; a request arriving during APPLY is treated like one from IDLE.
            case (state)
                COMMIT_PENDING: begin
                    if (abort_req) begin
                        state   <= COMMIT_IDLE;
                        pending <= 1'b0;
                    end else if (!capture_busy) begin
                        state   <= COMMIT_APPLY;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    if (abort_req || !commit_req) begin
                        state   <= COMMIT_IDLE;
                        pending <= 1'b0;
                    end else if (capture_busy) begin
                        state   <= COMMIT_PENDING;
                        pending <= 1'b1;
                    end else begin
                        state   <= COMMIT_APPLY;
                        pending <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
`endif

// File: rtl/reg_adc_chanbank.sv
// Multi-channel ADC settings register bank on the USB register bus.
// REG_CHANBANK_SHADOW_EN adds shadow registers with an atomic, busy-deferred commit.
module reg_adc_chanbank
    import reg_adc_chanbank_pkg::*;
#(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pNUM_CHANNELS = 4,
    parameter int pGAIN_WIDTH   = 8,
    parameter int pLEVEL_WIDTH  = 12
) (
    input  logic                                   clk_usb,
    input  logic                                   reset_n,
    input  logic [7:0]                             reg_address,
    input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    input  logic [7:0]                             reg_datai,
    output logic [7:0]                             reg_datao,
    input  logic                                   reg_read,
    input  logic                                   reg_write,
    input  logic                                   capture_busy_i,
    output logic [pNUM_CHANNELS*pGAIN_WIDTH-1:0]   gain_o,
    output logic [pNUM_CHANNELS*pLEVEL_WIDTH-1:0]  trigger_level_o,
    output logic [pNUM_CHANNELS-1:0]               chan_enable_o,
    output logic                                   commit_pending_o,
    output logic                                   commit_done_o
);
    typedef logic [pGAIN_WIDTH-1:0]  gain_t;
    typedef logic [pLEVEL_WIDTH-1:0] level_t;

    logic byte0, byte1, byte2, byte3;
    logic wr_select, wr_gain, wr_level, wr_enable;
    logic [7:0] chan_sel;
    logic [pNUM_CHANNELS-1:0] shadow_en;
    logic [pNUM_CHANNELS*pGAIN_WIDTH-1:0]  shadow_gain;
    logic [pNUM_CHANNELS*pLEVEL_WIDTH-1:0] shadow_level;
    gain_t  sel_gain;
    level_t sel_level;
    logic [7:0]  commit_rd;
    logic [31:0] chan_info;

    assign byte0 = (reg_bytecnt == pBYTECNT_SIZE'(0));
    assign byte1 = (reg_bytecnt == pBYTECNT_SIZE'(1));
    assign byte2 = (reg_bytecnt == pBYTECNT_SIZE'(2));
    assign byte3 = (reg_bytecnt == pBYTECNT_SIZE'(3));

    assign wr_select = reg_write && (reg_address == CHAN_SELECT_ADDR) && byte0;
    assign wr_gain   = reg_write && (reg_address == CHAN_GAIN_ADDR);
    assign wr_level  = reg_write && (reg_address == CHAN_LEVEL_ADDR);
    assign wr_enable = reg_write && (reg_address == CHAN_ENABLE_ADDR) && byte0;

    assign chan_info = {8'(pNUM_CHANNELS), 8'(pGAIN_WIDTH), 8'(pLEVEL_WIDTH), 8'h01};

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            chan_sel  <= 8'h00;
            shadow_en <= pNUM_CHANNELS'(1);
        end else begin
            if (wr_select) chan_sel  <= reg_datai;
            if (wr_enable) shadow_en <= reg_datai[pNUM_CHANNELS-1:0];
        end
    end

`ifdef REG_CHANBANK_SHADOW_EN
    logic wr_commit, rd_commit, apply, pending, overrun;

    assign wr_commit = reg_write && (reg_address == CHAN_COMMIT_ADDR) && byte0;
    assign rd_commit = reg_read && (reg_address == CHAN_COMMIT_ADDR);

    reg_commit_fsm u_commit_fsm (
        .clk_usb       (clk_usb),
        .reset_n       (reset_n),
        .commit_req    (wr_commit && reg_datai[0]),
        .abort_req     (wr_commit && reg_datai[1]),
        .capture_busy  (capture_busy_i),
        .overrun_clear (rd_commit),
        .apply         (apply),
        .pending       (pending),
        .done          (commit_done_o),
        .overrun       (overrun)
    );

    assign commit_pending_o = pending;
    assign commit_rd        = {6'b0, pending, overrun};

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)   chan_enable_o <= pNUM_CHANNELS'(1);
        else if (apply) chan_enable_o <= shadow_en;
    end
`else
    logic unused_busy;

    assign unused_busy      = capture_busy_i;
    assign commit_pending_o = 1'b0;
    assign commit_done_o    = 1'b0;
    assign commit_rd        = 8'h00;
    assign chan_enable_o    = shadow_en;
`endif

    for (genvar n = 0; n < pNUM_CHANNELS; n++) begin : g_chan
        logic   hit;
        gain_t  gain_q;
        level_t level_q;

        assign hit = (chan_sel == 8'(n));
        assign shadow_gain[n*pGAIN_WIDTH +: pGAIN_WIDTH]    = gain_q;
        assign shadow_level[n*pLEVEL_WIDTH +: pLEVEL_WIDTH] = level_q;

        always_ff @(posedge clk_usb or negedge reset_n) begin
            if (!reset_n) begin
                gain_q  <= '0;
                level_q <= '0;
            end else begin
                if (wr_gain && hit)
                    gain_q <= gain_t'(merge_byte16(16'(gain_q), reg_datai, byte0, byte1));
                if (wr_level && hit)
                    level_q <= level_t'(merge_byte16(16'(level_q), reg_datai, byte0, byte1));
            end
        end

`ifdef REG_CHANBANK_SHADOW_EN
        always_ff @(posedge clk_usb or negedge reset_n) begin
            if (!reset_n) begin
                gain_o[n*pGAIN_WIDTH +: pGAIN_WIDTH]            <= '0;
                trigger_level_o[n*pLEVEL_WIDTH +: pLEVEL_WIDTH] <= '0;
            end else if (apply) begin
                gain_o[n*pGAIN_WIDTH +: pGAIN_WIDTH]            <= gain_q;
                trigger_level_o[n*pLEVEL_WIDTH +: pLEVEL_WIDTH] <= level_q;
            end
        end
`else
        assign gain_o[n*pGAIN_WIDTH +: pGAIN_WIDTH]            = gain_q;
        assign trigger_level_o[n*pLEVEL_WIDTH +: pLEVEL_WIDTH] = level_q;
`endif
    end

    // An out-of-range selector matches no channel, so its reads fall back to zero.
    always_comb begin
        sel_gain  = '0;
        sel_level = '0;
        for (int n = 0; n < pNUM_CHANNELS; n++) begin
            if (chan_sel == 8'(n)) begin
                sel_gain  = shadow_gain[n*pGAIN_WIDTH +: pGAIN_WIDTH];
                sel_level = shadow_level[n*pLEVEL_WIDTH +: pLEVEL_WIDTH];
            end
        end
    end

    always_comb begin
        reg_datao = 8'h00;
        if (reg_read) begin
            case (reg_address)
                CHAN_SELECT_ADDR: reg_datao = byte0 ? chan_sel : 8'h00;
                CHAN_GAIN_ADDR:   reg_datao = read_byte16(16'(sel_gain), byte0, byte1);
                CHAN_LEVEL_ADDR:  reg_datao = read_byte16(16'(sel_level), byte0, byte1);
                CHAN_ENABLE_ADDR: reg_datao = byte0 ? 8'(shadow_en) : 8'h00;
                CHAN_COMMIT_ADDR: reg_datao = byte0 ? commit_rd : 8'h00;
                CHAN_INFO_ADDR: begin
                    if (byte0)      reg_datao = chan_info[7:0];
                    else if (byte1) reg_datao = chan_info[15:8];
                    else if (byte2) reg_datao = chan_info[23:16];
                    else if (byte3) reg_datao = chan_info[31:24];
                end
                default: reg_datao = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_adc_chanbank.sv
// Directed, table-driven bench for reg_adc_chanbank; covers both the direct-write
// build and the REG_CHANBANK_SHADOW_EN commit build.
module tb_reg_adc_chanbank;
    import reg_adc_chanbank_pkg::*;

    logic        clk_usb = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  reg_address = 8'h00;
    logic [6:0]  reg_bytecnt = 7'd0;
    logic [7:0]  reg_datai = 8'h00;
    logic [7:0]  reg_datao;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        capture_busy_i = 1'b0;
    logic [31:0] gain_o;
    logic [47:0] trigger_level_o;
    logic [3:0]  chan_enable_o;
    logic        commit_pending_o;
    logic        commit_done_o;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_ref;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [6:0] bcnt;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [18];

    reg_adc_chanbank dut (
        .clk_usb          (clk_usb),
        .reset_n          (reset_n),
        .reg_address      (reg_address),
        .reg_bytecnt      (reg_bytecnt),
        .reg_datai        (reg_datai),
        .reg_datao        (reg_datao),
        .reg_read         (reg_read),
        .reg_write        (reg_write),
        .capture_busy_i   (capture_busy_i),
        .gain_o           (gain_o),
        .trigger_level_o  (trigger_level_o),
        .chan_enable_o    (chan_enable_o),
        .commit_pending_o (commit_pending_o),
        .commit_done_o    (commit_done_o)
    );

    always #5 clk_usb = ~clk_usb;

    always @(negedge clk_usb) if (commit_done_o) done_cnt++;

    task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit is_wr, input logic [7:0] addr, input logic [6:0] bcnt,
                                  input logic [7:0] data);
        @(negedge clk_usb);
        reg_address = addr;
        reg_bytecnt = bcnt;
        reg_datai   = data;
        reg_write   = is_wr;
        reg_read    = !is_wr;
        #2;
    endtask

    task automatic end_stimulus();
        @(negedge clk_usb);
        reg_write = 1'b0;
        reg_read  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [6:0] bcnt, input logic [7:0] data);
        apply_stimulus(1'b1, addr, bcnt, data);
        end_stimulus();
    endtask

    task automatic rd_check(input string name, input logic [7:0] addr, input logic [6:0] bcnt,
                            input logic [7:0] exp);
        apply_stimulus(1'b0, addr, bcnt, 8'h00);
        check_output(name, 48'(reg_datao), 48'(exp));
        end_stimulus();
    endtask

    initial begin
        vecs[0]  = '{1'b0, CHAN_INFO_ADDR,   7'd0, 8'h00, 8'h01};
        vecs[1]  = '{1'b0, CHAN_INFO_ADDR,   7'd1, 8'h00, 8'h0C};
        vecs[2]  = '{1'b0, CHAN_INFO_ADDR,   7'd2, 8'h00, 8'h08};
        vecs[3]  = '{1'b0, CHAN_INFO_ADDR,   7'd3, 8'h00, 8'h04};
        vecs[4]  = '{1'b0, CHAN_INFO_ADDR,   7'd4, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, CHAN_ENABLE_ADDR, 7'd0, 8'h00, 8'h01};
        vecs[6]  = '{1'b0, CHAN_SELECT_ADDR, 7'd0, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, CHAN_SELECT_ADDR, 7'd0, 8'h02, 8'h00};
        vecs[8]  = '{1'b1, CHAN_LEVEL_ADDR,  7'd0, 8'hAB, 8'h00};
        vecs[9]  = '{1'b1, CHAN_LEVEL_ADDR,  7'd1, 8'h0F, 8'h00};
        vecs[10] = '{1'b0, CHAN_LEVEL_ADDR,  7'd0, 8'h00, 8'hAB};
        vecs[11] = '{1'b0, CHAN_LEVEL_ADDR,  7'd1, 8'h00, 8'h0F};
        vecs[12] = '{1'b1, CHAN_LEVEL_ADDR,  7'd1, 8'hFF, 8'h00};
        vecs[13] = '{1'b0, CHAN_LEVEL_ADDR,  7'd1, 8'h00, 8'h0F};
        vecs[14] = '{1'b1, CHAN_LEVEL_ADDR,  7'd2, 8'h55, 8'h00};
        vecs[15] = '{1'b0, CHAN_LEVEL_ADDR,  7'd2, 8'h00, 8'h00};
        vecs[16] = '{1'b0, CHAN_GAIN_ADDR,   7'd1, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 8'h99,            7'd0, 8'h00, 8'h00};

        repeat (3) @(negedge clk_usb);
        check_output("rst_gain", 48'(gain_o), 48'h0);
        check_output("rst_level", trigger_level_o, 48'h0);
        check_output("rst_enable", 48'(chan_enable_o), 48'h1);
        check_output("rst_pending", 48'(commit_pending_o), 48'h0);
        reset_n = 1'b1;
        @(negedge clk_usb);
        check_output("idle_datao", 48'(reg_datao), 48'h0);

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].is_wr, vecs[i].addr, vecs[i].bcnt, vecs[i].data);
            if (!vecs[i].is_wr)
                check_output($sformatf("vec%0d", i), 48'(reg_datao), 48'(vecs[i].exp));
            end_stimulus();
        end

`ifdef REG_CHANBANK_SHADOW_EN
        check_output("level_before_commit", trigger_level_o, 48'h0);
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        check_output("apply_cycle_level", trigger_level_o, 48'h0);
        check_output("apply_cycle_done", 48'(commit_done_o), 48'h0);
        @(negedge clk_usb);
        check_output("commit_level", trigger_level_o, 48'h000_FAB_000_000);
        check_output("commit_done_hi", 48'(commit_done_o), 48'h1);
        @(negedge clk_usb);
        check_output("commit_done_lo", 48'(commit_done_o), 48'h0);

        capture_busy_i = 1'b1;
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        check_output("busy_pending", 48'(commit_pending_o), 48'h1);
        wr(CHAN_SELECT_ADDR, 7'd0, 8'h01);
        wr(CHAN_GAIN_ADDR, 7'd0, 8'h55);
        check_output("busy_gain_held", 48'(gain_o), 48'h0);
        capture_busy_i = 1'b0;
        @(negedge clk_usb);
        check_output("busy_drop_pending", 48'(commit_pending_o), 48'h0);
        check_output("busy_drop_gain", 48'(gain_o), 48'h0);
        @(negedge clk_usb);
        check_output("deferred_gain", 48'(gain_o), 48'h5500);
        check_output("deferred_done", 48'(commit_done_o), 48'h1);

        capture_busy_i = 1'b1;
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        rd_check("overrun_set", CHAN_COMMIT_ADDR, 7'd0, 8'h03);
        rd_check("overrun_clr", CHAN_COMMIT_ADDR, 7'd0, 8'h02);
        wr(CHAN_GAIN_ADDR, 7'd0, 8'h77);
        done_ref = done_cnt;
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h03);
        check_output("abort_pending", 48'(commit_pending_o), 48'h0);
        capture_busy_i = 1'b0;
        repeat (3) @(negedge clk_usb);
        check_output("abort_no_done", 48'(done_cnt), 48'(done_ref));
        check_output("abort_gain", 48'(gain_o), 48'h5500);

        wr(CHAN_ENABLE_ADDR, 7'd0, 8'h0A);
        wr(CHAN_SELECT_ADDR, 7'd0, 8'h07);
        wr(CHAN_GAIN_ADDR, 7'd0, 8'h33);
        rd_check("oor_gain_rd", CHAN_GAIN_ADDR, 7'd0, 8'h00);
        rd_check("oor_select_rd", CHAN_SELECT_ADDR, 7'd0, 8'h07);
        check_output("enable_held", 48'(chan_enable_o), 48'h1);
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        @(negedge clk_usb);
        check_output("oor_gain_live", 48'(gain_o), 48'h7700);
        check_output("enable_live", 48'(chan_enable_o), 48'hA);
        check_output("level_kept", trigger_level_o, 48'h000_FAB_000_000);

        capture_busy_i = 1'b1;
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        check_output("pre_reset_pending", 48'(commit_pending_o), 48'h1);
`else
        check_output("direct_level", trigger_level_o, 48'h000_FAB_000_000);
        wr(CHAN_SELECT_ADDR, 7'd0, 8'h01);
        wr(CHAN_GAIN_ADDR, 7'd0, 8'h55);
        check_output("direct_gain", 48'(gain_o), 48'h5500);
        capture_busy_i = 1'b1;
        wr(CHAN_COMMIT_ADDR, 7'd0, 8'h01);
        check_output("direct_pending", 48'(commit_pending_o), 48'h0);
        rd_check("direct_commit_rd", CHAN_COMMIT_ADDR, 7'd0, 8'h00);
        check_output("direct_no_done", 48'(done_cnt), 48'h0);
        capture_busy_i = 1'b0;
        wr(CHAN_SELECT_ADDR, 7'd0, 8'h07);
        wr(CHAN_GAIN_ADDR, 7'd0, 8'h33);
        check_output("oor_gain_live", 48'(gain_o), 48'h5500);
        rd_check("oor_gain_rd", CHAN_GAIN_ADDR, 7'd0, 8'h00);
        wr(CHAN_ENABLE_ADDR, 7'd0, 8'hFF);
        check_output("enable_live", 48'(chan_enable_o), 48'hF);
        rd_check("enable_rd", CHAN_ENABLE_ADDR, 7'd0, 8'h0F);
`endif

        #3 reset_n = 1'b0;
        #1;
        check_output("async_rst_pending", 48'(commit_pending_o), 48'h0);
        check_output("async_rst_gain", 48'(gain_o), 48'h0);
        check_output("async_rst_level", trigger_level_o, 48'h0);
        check_output("async_rst_enable", 48'(chan_enable_o), 48'h1);
        done_ref = done_cnt;
        @(negedge clk_usb);
        reset_n = 1'b1;
        capture_busy_i = 1'b0;
        repeat (3) @(negedge clk_usb);
        check_output("post_rst_gain", 48'(gain_o), 48'h0);
        check_output("post_rst_enable", 48'(chan_enable_o), 48'h1);
        check_output("post_rst_no_done", 48'(done_cnt), 48'(done_ref));
        rd_check("post_rst_select", CHAN_SELECT_ADDR, 7'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
